// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache controllers, the arbiter and main memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req0, req1;
  logic              rd0, rd1;
  logic              wr0, wr1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] din0, din1;
  logic              gnt0, gnt1;
  logic              stall0, stall1;
  logic              err0, err1;
  logic [DATA_W-1:0] dout;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_rd, mem_wr;
  logic [DATA_W-1:0] mem_dout;
  logic              mem_stall, mem_err;

  modport slave (
    input  req0, req1, rd0, rd1, wr0, wr1, addr0, addr1, din0, din1,
    input  mem_dout, mem_stall, mem_err,
    output gnt0, gnt1, stall0, stall1, err0, err1, dout,
    output mem_addr, mem_din, mem_rd, mem_wr
  );

  modport master (
    output req0, req1, rd0, rd1, wr0, wr1, addr0, addr1, din0, din1,
    output mem_dout, mem_stall, mem_err,
    input  gnt0, gnt1, stall0, stall1, err0, err1, dout,
    input  mem_addr, mem_din, mem_rd, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port burst arbiter in front of main memory (port 0 = I-cache, port 1 = D-cache).
// Ownership is held for a whole burst plus a drain window covering memory read latency.
module mem_arbiter #(
  parameter int DRAIN_CYCLES = 2,
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic [1:0]        gnt_q, gnt_d;

  logic [1:0]        req, rd, wr;
  logic [1:0]        owned, driving, stall, err;
  logic [ADDR_W-1:0] addr [2];
  logic [DATA_W-1:0] din  [2];

  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_din_c;
  logic              mem_rd_c, mem_wr_c;

  assign req     = {bus.req1, bus.req0};
  assign rd      = {bus.rd1, bus.rd0};
  assign wr      = {bus.wr1, bus.wr0};
  assign addr[0] = bus.addr0;
  assign addr[1] = bus.addr1;
  assign din[0]  = bus.din0;
  assign din[1]  = bus.din1;

  // owned covers OWN and DRAIN; driving is the subset where commands reach memory.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign owned[gi]   = (state_q != IDLE) && (owner_q == 1'(gi));
    assign driving[gi] = owned[gi] && (state_q != DRAIN);
    assign stall[gi]   = owned[gi] ? bus.mem_stall : 1'b1;
    assign err[gi]     = owned[gi] && (bus.mem_err || (driving[gi] && rd[gi] && wr[gi]));
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      IDLE: begin
        // On a tie the port that did not win last time is served.
        if (req[0] && (!req[1] || last_q)) begin
          state_d = OWN0;
          owner_d = 1'b0;
          last_d  = 1'b0;
        end else if (req[1]) begin
          state_d = OWN1;
          owner_d = 1'b1;
          last_d  = 1'b1;
        end
      end
      OWN0, OWN1: begin
        if (!req[owner_q] && !bus.mem_stall) begin
          state_d     = DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        // A stalled memory stretches the read latency, so the window pauses too.
        if (!bus.mem_stall) begin
          if (drain_cnt_q != '0) begin
            drain_cnt_d = drain_cnt_q - 1'b1;
          end else if (req[~owner_q]) begin
            state_d = owner_q ? OWN0 : OWN1;
            owner_d = ~owner_q;
            last_d  = ~owner_q;
          end else if (req[owner_q]) begin
            state_d = owner_q ? OWN1 : OWN0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    gnt_d[0] = (state_d == OWN0) || ((state_d == DRAIN) && !owner_d);
    gnt_d[1] = (state_d == OWN1) || ((state_d == DRAIN) && owner_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      drain_cnt_q <= '0;
      gnt_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      drain_cnt_q <= drain_cnt_d;
      gnt_q       <= gnt_d;
    end
  end

  always_comb begin
    mem_addr_c = '0;
    mem_din_c  = '0;
    mem_rd_c   = 1'b0;
    mem_wr_c   = 1'b0;
    if (driving[0]) begin
      mem_addr_c = addr[0];
      mem_din_c  = din[0];
      mem_rd_c   = rd[0];
      mem_wr_c   = wr[0];
    end else if (driving[1]) begin
      mem_addr_c = addr[1];
      mem_din_c  = din[1];
      mem_rd_c   = rd[1];
      mem_wr_c   = wr[1];
    end
  end

  assign bus.mem_addr = mem_addr_c;
  assign bus.mem_din  = mem_din_c;
  assign bus.mem_rd   = mem_rd_c;
  assign bus.mem_wr   = mem_wr_c;
  assign bus.gnt0     = gnt_q[0];
  assign bus.gnt1     = gnt_q[1];
  assign bus.stall0   = stall[0];
  assign bus.stall1   = stall[1];
  assign bus.err0     = err[0];
  assign bus.err1     = err[1];
  assign bus.dout     = bus.mem_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one task per scenario, cycle 1 is the first cycle after reset.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_arbiter #(.DRAIN_CYCLES(2), .ADDR_W(16), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic clear_inputs();
    bus.req0 = 0; bus.req1 = 0; bus.rd0 = 0; bus.rd1 = 0; bus.wr0 = 0; bus.wr1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.din0 = '0; bus.din1 = '0;
    bus.mem_dout = '0; bus.mem_stall = 0; bus.mem_err = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.req0 = 1; bus.rd0 = 1; bus.addr0 = 16'h1111; bus.mem_err = 1; bus.mem_dout = 16'h1357;
    rst = 1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    total++;
    if ({bus.gnt0, bus.gnt1, bus.stall0, bus.stall1, bus.mem_rd, bus.mem_wr} !== 6'b001100) begin
      bad++;
      $display("FAIL reset_status got=%b want=001100",
               {bus.gnt0, bus.gnt1, bus.stall0, bus.stall1, bus.mem_rd, bus.mem_wr});
    end
    total++;
    if ({bus.err0, bus.err1} !== 2'b00) begin
      bad++;
      $display("FAIL reset_err got=%b want=00", {bus.err0, bus.err1});
    end
    total++;
    if ({bus.mem_addr, bus.mem_din} !== 32'h0) begin
      bad++;
      $display("FAIL reset_membus got=%h want=00000000", {bus.mem_addr, bus.mem_din});
    end
    total++;
    if (bus.dout !== 16'h1357) begin
      bad++;
      $display("FAIL reset_dout got=%h want=1357", bus.dout);
    end
    $display("reset: checked gnt/stall/err/mem outputs under reset");
    rst = 0;
    clear_inputs();
  endtask

  // Single 4-read fill by port 0; drain occupies cycles 6-7.
  task automatic test_single_fill();
    logic [5:0]  want;
    logic [15:0] want_addr;
    logic        g0, r;
    apply_reset();
    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      bus.req0 = (c <= 4);
      bus.rd0  = (c >= 2 && c <= 5);
      bus.addr0 = 16'h0100 + 16'(c);
      bus.mem_dout = 16'hA000 + 16'(c);
      @(negedge clk);
      g0 = (c >= 2 && c <= 7);
      r  = (c >= 2 && c <= 5);
      want = {g0, 1'b0, !g0, 1'b1, r, 1'b0};
      want_addr = r ? (16'h0100 + 16'(c)) : 16'h0000;
      total++;
      if ({bus.gnt0, bus.gnt1, bus.stall0, bus.stall1, bus.mem_rd, bus.mem_wr} !== want) begin
        bad++;
        $display("FAIL fill_status c=%0d got=%b want=%b", c,
                 {bus.gnt0, bus.gnt1, bus.stall0, bus.stall1, bus.mem_rd, bus.mem_wr}, want);
      end
      total++;
      if (bus.mem_addr !== want_addr || bus.dout !== 16'hA000 + 16'(c)) begin
        bad++;
        $display("FAIL fill_addr c=%0d got=%h/%h want=%h/%h", c, bus.mem_addr, bus.dout,
                 want_addr, 16'hA000 + 16'(c));
      end
      $display("fill c=%0d gnt0=%b mem_rd=%b mem_addr=%h", c, bus.gnt0, bus.mem_rd, bus.mem_addr);
    end
    clear_inputs();
  endtask

  // Simultaneous requests: port 0 first, port 1 right after port 0's drain.
  task automatic test_tie();
    logic [5:0]  want;
    logic [15:0] want_addr;
    logic        g0, g1;
    apply_reset();
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      bus.req0 = (c <= 4);
      bus.rd0  = (c >= 2 && c <= 5);
      bus.addr0 = 16'h0100;
      bus.req1 = 1;
      bus.wr1  = (c >= 2);
      bus.addr1 = 16'h2000;
      @(negedge clk);
      g0 = (c >= 2 && c <= 7);
      g1 = (c >= 8);
      want = {g0, g1, !g0, !g1, (c >= 2 && c <= 5), g1};
      want_addr = (c >= 2 && c <= 5) ? 16'h0100 : (g1 ? 16'h2000 : 16'h0000);
      total++;
      if ({bus.gnt0, bus.gnt1, bus.stall0, bus.stall1, bus.mem_rd, bus.mem_wr} !== want) begin
        bad++;
        $display("FAIL tie_status c=%0d got=%b want=%b", c,
                 {bus.gnt0, bus.gnt1, bus.stall0, bus.stall1, bus.mem_rd, bus.mem_wr}, want);
      end
      total++;
      if (bus.mem_addr !== want_addr) begin
        bad++;
        $display("FAIL tie_addr c=%0d got=%h want=%h", c, bus.mem_addr, want_addr);
      end
      $display("tie c=%0d gnt0=%b gnt1=%b mem_addr=%h", c, bus.gnt0, bus.gnt1, bus.mem_addr);
    end
    clear_inputs();
  endtask

  // Port 1 writes while port 0 waits with its own write asserted.
  task automatic test_isolation();
    logic [5:0]  want;
    logic [31:0] want_bus;
    logic        g0, g1, w1;
    apply_reset();
    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      bus.req1 = (c <= 4);
      bus.wr1  = (c >= 2 && c <= 5);
      bus.addr1 = 16'h1230; bus.din1 = 16'h5A5A;
      bus.req0 = (c >= 2);
      bus.wr0  = (c >= 2);
      bus.addr0 = 16'hBEEF; bus.din0 = 16'hDEAD;
      @(negedge clk);
      g1 = (c >= 2 && c <= 7);
      g0 = (c >= 8);
      w1 = (c >= 2 && c <= 5);
      want = {g0, g1, !g0, !g1, 1'b0, w1 || g0};
      want_bus = w1 ? 32'h1230_5A5A : (g0 ? 32'hBEEF_DEAD : 32'h0);
      total++;
      if ({bus.gnt0, bus.gnt1, bus.stall0, bus.stall1, bus.mem_rd, bus.mem_wr} !== want) begin
        bad++;
        $display("FAIL iso_status c=%0d got=%b want=%b", c,
                 {bus.gnt0, bus.gnt1, bus.stall0, bus.stall1, bus.mem_rd, bus.mem_wr}, want);
      end
      total++;
      if ({bus.mem_addr, bus.mem_din} !== want_bus) begin
        bad++;
        $display("FAIL iso_membus c=%0d got=%h want=%h", c, {bus.mem_addr, bus.mem_din}, want_bus);
      end
      $display("iso c=%0d gnt=%b%b mem_wr=%b mem_addr=%h", c, bus.gnt0, bus.gnt1, bus.mem_wr, bus.mem_addr);
    end
    clear_inputs();
  endtask

  // Error routing: protocol error in OWN1, mem_err in DRAIN of owner 1, mem_err in IDLE dropped.
  task automatic test_errors();
    logic [1:0] want_err;
    logic [5:0] want;
    logic       g1;
    apply_reset();
    for (int c = 1; c <= 7; c++) begin
      next_cycle();
      bus.req1 = (c <= 2);
      bus.rd1  = (c == 2);
      bus.wr1  = (c == 2);
      bus.rd0  = 1;
      bus.wr0  = 1;
      bus.mem_err = (c == 4 || c == 6);
      @(negedge clk);
      g1 = (c >= 2 && c <= 5);
      want_err = {1'b0, (c == 2 || c == 4)};
      want = {1'b0, g1, 1'b1, !g1, (c == 2), (c == 2)};
      total++;
      if ({bus.err0, bus.err1} !== want_err) begin
        bad++;
        $display("FAIL err_route c=%0d got=%b want=%b", c, {bus.err0, bus.err1}, want_err);
      end
      total++;
      if ({bus.gnt0, bus.gnt1, bus.stall0, bus.stall1, bus.mem_rd, bus.mem_wr} !== want) begin
        bad++;
        $display("FAIL err_status c=%0d got=%b want=%b", c,
                 {bus.gnt0, bus.gnt1, bus.stall0, bus.stall1, bus.mem_rd, bus.mem_wr}, want);
      end
      $display("err c=%0d mem_err=%b err0=%b err1=%b", c, bus.mem_err, bus.err0, bus.err1);
    end
    clear_inputs();
  endtask

  // Reset in the middle of an OWN0 burst: no drain, and the next tie goes to port 0.
  task automatic test_reset_mid_burst();
    apply_reset();
    next_cycle();
    bus.req0 = 1;
    next_cycle();
    bus.rd0 = 1; bus.addr0 = 16'h3333;
    next_cycle();
    @(negedge clk);
    total++;
    if ({bus.gnt0, bus.mem_rd, bus.mem_addr} !== {1'b1, 1'b1, 16'h3333}) begin
      bad++;
      $display("FAIL midrst_pre got=%b%b/%h want=11/3333", bus.gnt0, bus.mem_rd, bus.mem_addr);
    end
    rst = 1;
    next_cycle();
    rst = 0;
    bus.req1 = 1;
    @(negedge clk);
    total++;
    if ({bus.gnt0, bus.gnt1, bus.stall0, bus.mem_rd, bus.mem_wr, bus.mem_addr} !== {5'b00100, 16'h0000}) begin
      bad++;
      $display("FAIL midrst_abort got=%b%b%b%b%b/%h want=00100/0000",
               bus.gnt0, bus.gnt1, bus.stall0, bus.mem_rd, bus.mem_wr, bus.mem_addr);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      bad++;
      $display("FAIL midrst_tie got=%b want=10", {bus.gnt0, bus.gnt1});
    end
    $display("midrst: after reset gnt0=%b gnt1=%b", bus.gnt0, bus.gnt1);
    clear_inputs();
  endtask

  // mem_stall holds ownership after req0 drops; drain starts once the stall clears.
  task automatic test_stall_hold();
    logic        g0, st0;
    logic [15:0] want_addr;
    apply_reset();
    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      bus.req0 = (c <= 2);
      bus.addr0 = 16'h4444;
      bus.mem_stall = (c >= 3 && c <= 5);
      @(negedge clk);
      g0 = (c >= 2 && c <= 8);
      st0 = !g0 || (c >= 3 && c <= 5);
      want_addr = (c >= 2 && c <= 6) ? 16'h4444 : 16'h0000;
      total++;
      if ({bus.gnt0, bus.stall0, bus.mem_addr} !== {g0, st0, want_addr}) begin
        bad++;
        $display("FAIL stall_hold c=%0d got=%b%b/%h want=%b%b/%h", c,
                 bus.gnt0, bus.stall0, bus.mem_addr, g0, st0, want_addr);
      end
      $display("stall c=%0d mem_stall=%b gnt0=%b stall0=%b mem_addr=%h", c,
               bus.mem_stall, bus.gnt0, bus.stall0, bus.mem_addr);
    end
    clear_inputs();
  endtask

  // Same owner re-requests during drain with no competitor: re-granted without an IDLE cycle.
  task automatic test_back_to_back();
    logic        g0;
    logic [15:0] want_addr;
    apply_reset();
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      bus.req0 = (c == 1 || c >= 3);
      bus.addr0 = 16'h7777;
      @(negedge clk);
      g0 = (c >= 2);
      want_addr = (c == 2 || c >= 5) ? 16'h7777 : 16'h0000;
      total++;
      if ({bus.gnt0, bus.gnt1, bus.mem_addr} !== {g0, 1'b0, want_addr}) begin
        bad++;
        $display("FAIL b2b c=%0d got=%b%b/%h want=%b0/%h", c,
                 bus.gnt0, bus.gnt1, bus.mem_addr, g0, want_addr);
      end
      $display("b2b c=%0d gnt0=%b mem_addr=%h", c, bus.gnt0, bus.mem_addr);
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_fill();
    test_tie();
    test_isolation();
    test_errors();
    test_reset_mid_burst();
    test_stall_hold();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
